// File: rtl/system_saida_pio.sv
// system_saida_pio: Avalon-MM output PIO driving out_port with a valid/ack handshake,
// set/clear bit access and a sticky overrun status flag.
module system_saida_pio #(
    parameter int          DATA_WIDTH  = 19,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);
    logic [DATA_WIDTH-1:0] data_q, data_d, wd;
    logic                  valid_q, valid_d, ovr_q, ovr_d, wr, data_wr;
    logic [31:0]           rd_d;
    assign out_port  = data_q;
    assign out_valid = valid_q;
    always_comb begin
        wr      = chipselect & ~write_n;
        data_wr = wr & (address != 2'd1);
        wd      = writedata[DATA_WIDTH-1:0];
        data_d  = !data_wr ? data_q : address == 2'd0 ? wd : address == 2'd2 ? data_q | wd : data_q & ~wd;
        // a write in the same cycle as ack replaces the consumed value, so it stays pending
        valid_d = data_wr | (valid_q & ~out_ack);
        ovr_d   = (data_wr & valid_q & ~out_ack) | (ovr_q & ~(wr & address == 2'd1 & writedata[1]));
        rd_d    = address == 2'd0 ? 32'(data_q) : address == 2'd1 ? {30'd0, ovr_q, valid_q} : 32'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[DATA_WIDTH-1:0];
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            readdata <= 32'd0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            readdata <= rd_d;
        end
    end
endmodule

// File: tb/tb_system_saida_pio.sv
// tb_system_saida_pio: directed plus randomized checks of system_saida_pio against a
// register-map level reference model.
module tb_system_saida_pio;
    localparam logic [31:0] MASK = 32'h0007FFFF;
    logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1, out_ack = 0;
    logic [1:0]  address = 0;
    logic [31:0] writedata = 0, readdata;
    logic [18:0] out_port;
    logic        out_valid;
    int          pass_cnt = 0, total = 0;
    logic [31:0] m_data, m_rd;
    bit          m_valid, m_ov;

    always #5 clk = ~clk;

    system_saida_pio #(.DATA_WIDTH(19), .RESET_VALUE(32'd0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .out_ack(out_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_data = 0; m_rd = 0; m_valid = 0; m_ov = 0;
    endtask

    task automatic cyc(input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] wd, input bit ack);
        logic [31:0] w;
        bit wr, dw;
        chipselect = cs; write_n = wn; address = a; writedata = wd; out_ack = ack;
        @(posedge clk);
        w  = wd & MASK;
        wr = cs && !wn;
        dw = wr && a != 2'd1;
        m_rd = a == 2'd0 ? m_data : a == 2'd1 ? {30'd0, m_ov, m_valid} : 32'd0;
        if (wr && a == 2'd1 && wd[1]) m_ov = 0;
        if (dw && m_valid && !ack) m_ov = 1;
        if (dw) begin
            m_data  = a == 2'd0 ? w : a == 2'd2 ? (m_data | w) : (m_data & ~w);
            m_valid = 1;
        end else if (ack) m_valid = 0;
        #1;
        check("out_port", 32'(out_port), m_data);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("readdata", readdata, m_rd);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        cyc(1, 0, a, wd, 0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1, 1, a, 0, 0);
    endtask

    task automatic idle(input bit ack);
        cyc(0, 1, 0, 0, ack);
    endtask

    initial begin
        model_reset();
        chipselect = 1; write_n = 0; address = 0; writedata = 32'h1234; out_ack = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_port", 32'(out_port), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_rd", readdata, 0);
        chipselect = 0; write_n = 1; out_ack = 0;
        @(negedge clk);
        reset_n = 1;
        rd(1); rd(1);
        check("rst_status", readdata, 0);

        wr_reg(0, 32'h7ABCD);
        check("data_port", 32'(out_port), 32'h7ABCD);
        check("data_valid", 32'(out_valid), 1);
        rd(0);
        check("rd_data", readdata, 32'h0007ABCD);
        rd(1);
        check("rd_busy", readdata, 32'h1);
        idle(1);
        check("ack_clear", 32'(out_valid), 0);

        wr_reg(0, 32'hF0); idle(1);
        wr_reg(2, 32'h0F);
        check("outset", 32'(out_port), 32'hFF);
        idle(1);
        wr_reg(3, 32'hF0);
        check("outclr", 32'(out_port), 32'h0F);
        check("outclr_valid", 32'(out_valid), 1);
        rd(2);
        check("rd_set", readdata, 0);
        rd(3);
        check("rd_clr", readdata, 0);
        idle(1);

        wr_reg(0, 32'h1); wr_reg(0, 32'h2); rd(1);
        check("ovr_port", 32'(out_port), 32'h2);
        check("ovr_status", readdata, 32'h3);
        wr_reg(1, 32'h2); rd(1);
        check("w1c", readdata, 32'h1);
        wr_reg(1, 32'h2); wr_reg(0, 32'h5); rd(1);
        check("ovr_again", readdata, 32'h3);

        idle(1); wr_reg(1, 32'h2); wr_reg(0, 32'h9);
        cyc(1, 0, 0, 32'hA, 1);
        check("coinc_valid", 32'(out_valid), 1);
        rd(1);
        check("coinc_status", readdata, 32'h1);
        idle(1);
        check("coinc_ack", 32'(out_valid), 0);

        wr_reg(0, 32'hFFFFFFFF);
        check("wide_port", 32'(out_port), 32'h7FFFF);
        rd(0);
        check("wide_rd", readdata, 32'h0007FFFF);
        #2 reset_n = 0;
        #1;
        check("async_port", 32'(out_port), 0);
        check("async_valid", 32'(out_valid), 0);
        check("async_rd", readdata, 0);
        model_reset();
        out_ack = 1;
        @(negedge clk);
        reset_n = 1;
        out_ack = 0;

        repeat (400)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 2) == 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
